// File: rtl/de_pipe_reg.sv
// D->E pipeline register: captures the decoded instruction and operands, inserts NOP bubbles,
// and while E is held it down-counts Tnew, ages the instruction and refreshes rs/rt from writeback.
module de_pipe_reg #(
    parameter int             W      = 32,
    parameter int             TNEW_W = 2,
    parameter int             AGE_W  = 8,
    parameter logic [W-1:0]   NOP    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              bubble,
    input  logic              clr,
    input  logic [W-1:0]      D_instr,
    input  logic [W-1:0]      D_pc,
    input  logic [W-1:0]      D_rs,
    input  logic [W-1:0]      D_rt,
    input  logic [W-1:0]      D_ext,
    input  logic [TNEW_W-1:0] D_tnew,
    input  logic              fwd_valid,
    input  logic [4:0]        fwd_addr,
    input  logic [W-1:0]      fwd_data,
    output logic [W-1:0]      E_instr,
    output logic [W-1:0]      E_pc,
    output logic [W-1:0]      E_rs,
    output logic [W-1:0]      E_rt,
    output logic [W-1:0]      E_ext,
    output logic [TNEW_W-1:0] E_tnew,
    output logic              E_valid,
    output logic [AGE_W-1:0]  E_age
);

    logic rs_hit;
    logic rt_hit;

    // Register 0 is hard-wired to zero, so a writeback to it must never refresh an operand.
    assign rs_hit = fwd_valid && (fwd_addr != 5'd0) && (fwd_addr == E_instr[25:21]);
    assign rt_hit = fwd_valid && (fwd_addr != 5'd0) && (fwd_addr == E_instr[20:16]);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            E_instr <= NOP;
            E_pc    <= '0;
            E_rs    <= '0;
            E_rt    <= '0;
            E_ext   <= '0;
            E_tnew  <= '0;
            E_valid <= 1'b0;
            E_age   <= '0;
        end else if (clr || (en && bubble)) begin
            E_instr <= NOP;
            E_pc    <= '0;
            E_rs    <= '0;
            E_rt    <= '0;
            E_ext   <= '0;
            E_tnew  <= '0;
            E_valid <= 1'b0;
            E_age   <= '0;
        end else if (en) begin
            E_instr <= D_instr;
            E_pc    <= D_pc;
            E_rs    <= D_rs;
            E_rt    <= D_rt;
            E_ext   <= D_ext;
            E_tnew  <= D_tnew;
            E_valid <= 1'b1;
            E_age   <= '0;
        end else begin
            // Held: Tnew and age both saturate rather than wrap.
            if (E_tnew != '0)
                E_tnew <= E_tnew - TNEW_W'(1);
            if (E_age != '1)
                E_age <= E_age + AGE_W'(1);
            if (rs_hit)
                E_rs <= fwd_data;
            if (rt_hit)
                E_rt <= fwd_data;
        end
    end

endmodule
